pc_sequencer: RTL and testbench

- Parametrised successor to the single-register program counter.
- Holds the fetch address and generates the next PC every cycle: sequential increment, stall hold, branch/jump redirect, halt/resume, and a reset vector.
- Sits between the control unit and instruction memory address port.
- Optional return-address stack accelerates call/return.

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer_ras.sv | 44 ++++
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// Package pc_pkg: FSM state enum, default alignment width, alignment-mask helper.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } pcState_t;

  localparam int INSN_BYTES_DEFAULT = 4;
  localparam int ALIGN_BITS         = $clog2(INSN_BYTES_DEFAULT);

  // Mask that keeps every bit above the low alignBits bits.
  function automatic logic [63:0] alignMask(input int alignBits);
    return ~((64'd1 << alignBits) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit <-> PC sequencer bundle: redirect requests in, fetch address out.
// master = control unit / fetch side, slave = pc_sequencer.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic              jump_valid;
  logic [ADDR_W-1:0] jump_target;
  logic              halt;
  logic              resume;
  logic              call_valid;
  logic              ret_valid;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic [ADDR_W-1:0] pc_next_seq;
  logic              misalign;
  logic              ras_underflow;

  modport master (
    output stall, branch_valid, branch_target, jump_valid, jump_target,
           halt, resume, call_valid, ret_valid,
    input  pc, pc_valid, pc_next_seq, misalign, ras_underflow
  );

  modport slave (
    input  stall, branch_valid, branch_target, jump_valid, jump_target,
           halt, resume, call_valid, ret_valid,
    output pc, pc_valid, pc_next_seq, misalign, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest
// entry and the count saturates at DEPTH. DEPTH must be a power of two, >= 2.
module pc_ras #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] pushAddr,
  output logic [ADDR_W-1:0] topAddr,
  output logic              empty
);
  localparam int                PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL  = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0]  ONE   = PTR_W'(1);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W:0]    count;

  // NOTE: storage has no reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushAddr;
  end

  // Pointer wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      count <= '0;
    end else if (push) begin
      wrPtr <= wrPtr + ONE;
      if (count != FULL) count <= count + 1'b1;
    end else if (pop && !empty) begin
      wrPtr <= wrPtr - ONE;
      count <= count - 1'b1;
    end
  end

  assign empty   = (count == '0);
  assign topAddr = mem[wrPtr - ONE];
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address generator (increment, stall, branch/jump, halt/resume).
// Define PC_SEQUENCER_RAS_EN to build the return-address stack for call/ret.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                INSN_BYTES   = 4,
  parameter int                RAS_DEPTH    = 4
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);
  typedef logic [ADDR_W-1:0] addr_t;

  localparam int          ALIGN_W   = $clog2(INSN_BYTES);
  localparam logic [63:0] MASK_64   = alignMask(ALIGN_W);
  localparam addr_t       ADDR_MASK = MASK_64[ADDR_W-1:0];
  localparam addr_t       STEP      = ADDR_W'(INSN_BYTES);

  pcState_t state, stateNext;
  addr_t    pcReg, pcNext, pcSeq, rasTop;
  logic     misalignReg, misalignNext;
  logic     underflowReg, underflowNext;
  logic     callReq, retReq, doPush, doPop, rasEmpty;
  logic     pcValid;

  assign pcSeq = pcReg + STEP;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= BOOT;
      pcReg        <= RESET_VECTOR;
      misalignReg  <= 1'b0;
      underflowReg <= 1'b0;
    end else begin
      state        <= stateNext;
      pcReg        <= pcNext;
      misalignReg  <= misalignNext;
      underflowReg <= underflowNext;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    stateNext     = state;
    pcNext        = pcReg;
    misalignNext  = 1'b0;
    underflowNext = 1'b0;
    doPush        = 1'b0;
    doPop         = 1'b0;
    unique case (state)
      BOOT:   stateNext = RUN;
      HALTED: if (bus.resume && !bus.halt) stateNext = RUN;
      RUN: begin
        if (bus.halt) begin
          stateNext = HALTED;
        end else if (bus.jump_valid || callReq) begin
          pcNext       = bus.jump_target & ADDR_MASK;
          misalignNext = |(bus.jump_target & ~ADDR_MASK);
          doPush       = callReq;
        end else if (retReq) begin
          // An empty stack degrades ret into a plain increment.
          doPop = !rasEmpty;
          if (rasEmpty) begin
            pcNext        = pcSeq;
            underflowNext = 1'b1;
          end else begin
            pcNext = rasTop;
          end
        end else if (bus.branch_valid) begin
          pcNext       = bus.branch_target & ADDR_MASK;
          misalignNext = |(bus.branch_target & ~ADDR_MASK);
        end else if (!bus.stall) begin
          pcNext = pcSeq;
        end
      end
      default: stateNext = BOOT;
    endcase
  end

  always_comb begin
    pcValid = (state == RUN);
  end

`ifdef PC_SEQUENCER_RAS_EN
  assign callReq = bus.call_valid;
  assign retReq  = bus.ret_valid;

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) uRas (
    .clk      (clk),
    .reset    (reset),
    .push     (doPush),
    .pop      (doPop),
    .pushAddr (pcSeq),
    .topAddr  (rasTop),
    .empty    (rasEmpty)
  );
`else
  localparam int unusedDepth = RAS_DEPTH;
  logic unusedRas;
  assign callReq   = 1'b0;
  assign retReq    = 1'b0;
  assign rasTop    = '0;
  assign rasEmpty  = 1'b1;
  assign unusedRas = ^{bus.call_valid, bus.ret_valid, doPush, doPop};
`endif

  assign bus.pc            = pcReg;
  assign bus.pc_valid      = pcValid;
  assign bus.pc_next_seq   = pcSeq;
  assign bus.misalign      = misalignReg;
  assign bus.ras_underflow = underflowReg;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (RESET_VECTOR = 0x400, 4-byte insns).
// RAS scenarios run only when PC_SEQUENCER_RAS_EN is defined.
module tb_pc_sequencer;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] RV     = 32'h0000_0400;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   passCount  = 0;
  int   checkCount = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  pc_sequencer #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (RV),
    .INSN_BYTES   (4),
    .RAS_DEPTH    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.branch_valid = 0; bus.branch_target = '0;
    bus.jump_valid = 0; bus.jump_target = '0; bus.halt = 0; bus.resume = 0;
    bus.call_valid = 0; bus.ret_valid = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick(); tick();
    if (bus.pc !== RV) $display("FAIL rst_pc got %h want %h", bus.pc, RV); else passCount++; checkCount++;
    if (bus.pc_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.pc_valid); else passCount++; checkCount++;
    if (bus.misalign !== 1'b0) $display("FAIL rst_misalign got %b want 0", bus.misalign); else passCount++; checkCount++;
    if (bus.ras_underflow !== 1'b0) $display("FAIL rst_underflow got %b want 0", bus.ras_underflow); else passCount++; checkCount++;
    reset = 0;
    #1;
    if (bus.pc_valid !== 1'b0) $display("FAIL boot_valid got %b want 0", bus.pc_valid); else passCount++; checkCount++;
    tick();
    if (bus.pc !== 32'h400 || bus.pc_valid !== 1'b1) $display("FAIL run_first got %h/%b want 00000400/1", bus.pc, bus.pc_valid); else passCount++; checkCount++;
    tick();
    if (bus.pc !== 32'h404) $display("FAIL run_inc1 got %h want 00000404", bus.pc); else passCount++; checkCount++;
    tick();
    if (bus.pc !== 32'h408) $display("FAIL run_inc2 got %h want 00000408", bus.pc); else passCount++; checkCount++;
  endtask

  task automatic test_stall();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.pc !== 32'h408) $display("FAIL stall_hold%0d got %h want 00000408", i, bus.pc); else passCount++; checkCount++;
    end
    bus.branch_valid = 1; bus.branch_target = 32'h100;
    tick();
    if (bus.pc !== 32'h100) $display("FAIL stall_branch got %h want 00000100", bus.pc); else passCount++; checkCount++;
    idle();
  endtask

  task automatic test_redirect();
    bus.jump_valid = 1; bus.jump_target = 32'h200;
    bus.branch_valid = 1; bus.branch_target = 32'h300;
    tick();
    if (bus.pc !== 32'h200) $display("FAIL jump_over_branch got %h want 00000200", bus.pc); else passCount++; checkCount++;
    if (bus.misalign !== 1'b0) $display("FAIL aligned_no_flag got %b want 0", bus.misalign); else passCount++; checkCount++;
    idle();
    bus.jump_valid = 1; bus.jump_target = 32'h203;
    tick();
    if (bus.pc !== 32'h200) $display("FAIL jump_align got %h want 00000200", bus.pc); else passCount++; checkCount++;
    if (bus.misalign !== 1'b1) $display("FAIL misalign_pulse got %b want 1", bus.misalign); else passCount++; checkCount++;
    idle();
    tick();
    if (bus.pc !== 32'h204 || bus.misalign !== 1'b0) $display("FAIL misalign_end got %h/%b want 00000204/0", bus.pc, bus.misalign); else passCount++; checkCount++;
  endtask

  task automatic test_wrap();
    bus.jump_valid = 1; bus.jump_target = 32'hFFFF_FFFC;
    tick();
    idle();
    if (bus.pc !== 32'hFFFF_FFFC) $display("FAIL wrap_top got %h want fffffffc", bus.pc); else passCount++; checkCount++;
    if (bus.pc_next_seq !== 32'h0) $display("FAIL wrap_seq got %h want 00000000", bus.pc_next_seq); else passCount++; checkCount++;
    tick();
    if (bus.pc !== 32'h0 || bus.misalign !== 1'b0) $display("FAIL wrap_zero got %h/%b want 00000000/0", bus.pc, bus.misalign); else passCount++; checkCount++;
    tick();
    if (bus.pc !== 32'h4) $display("FAIL wrap_after got %h want 00000004", bus.pc); else passCount++; checkCount++;
  endtask

  task automatic test_halt();
    bus.halt = 1;
    tick();
    if (bus.pc !== 32'h4 || bus.pc_valid !== 1'b0) $display("FAIL halt_enter got %h/%b want 00000004/0", bus.pc, bus.pc_valid); else passCount++; checkCount++;
    bus.halt = 0; bus.stall = 1; bus.jump_valid = 1; bus.jump_target = 32'h500;
    bus.branch_valid = 1; bus.branch_target = 32'h600; bus.call_valid = 1; bus.ret_valid = 1;
    tick();
    if (bus.pc !== 32'h4 || bus.pc_valid !== 1'b0) $display("FAIL halt_ignore got %h/%b want 00000004/0", bus.pc, bus.pc_valid); else passCount++; checkCount++;
    bus.halt = 1; bus.resume = 1;
    tick();
    if (bus.pc_valid !== 1'b0) $display("FAIL halt_resume_both got %b want 0", bus.pc_valid); else passCount++; checkCount++;
    bus.halt = 0;
    tick();
    if (bus.pc !== 32'h4 || bus.pc_valid !== 1'b1) $display("FAIL resume got %h/%b want 00000004/1", bus.pc, bus.pc_valid); else passCount++; checkCount++;
    idle();
    tick();
    if (bus.pc !== 32'h8) $display("FAIL resume_inc got %h want 00000008", bus.pc); else passCount++; checkCount++;
  endtask

  task automatic test_back_to_back();
    bus.branch_valid = 1; bus.branch_target = 32'h40;
    tick();
    if (bus.pc !== 32'h40) $display("FAIL b2b_first got %h want 00000040", bus.pc); else passCount++; checkCount++;
    bus.branch_target = 32'h81;
    tick();
    if (bus.pc !== 32'h80 || bus.misalign !== 1'b1) $display("FAIL b2b_second got %h/%b want 00000080/1", bus.pc, bus.misalign); else passCount++; checkCount++;
    idle();
    tick();
    if (bus.pc !== 32'h84 || bus.misalign !== 1'b0) $display("FAIL b2b_after got %h/%b want 00000084/0", bus.pc, bus.misalign); else passCount++; checkCount++;
  endtask

`ifdef PC_SEQUENCER_RAS_EN
  task automatic test_ras();
    logic [31:0] rets [4] = '{32'h4004, 32'h3004, 32'h2004, 32'h1004};
    bus.jump_valid = 1; bus.jump_target = 32'h10;
    tick();
    idle();
    bus.call_valid = 1; bus.jump_target = 32'h80;
    tick();
    if (bus.pc !== 32'h80) $display("FAIL call_target got %h want 00000080", bus.pc); else passCount++; checkCount++;
    idle();
    bus.ret_valid = 1;
    tick();
    if (bus.pc !== 32'h14 || bus.ras_underflow !== 1'b0) $display("FAIL ret_addr got %h/%b want 00000014/0", bus.pc, bus.ras_underflow); else passCount++; checkCount++;
    idle();
    bus.jump_valid = 1; bus.jump_target = 32'h10;
    tick();
    idle();
    for (int k = 1; k <= 5; k++) begin
      bus.call_valid = 1; bus.jump_target = 32'(k) * 32'h1000;
      tick();
      if (bus.pc !== 32'(k) * 32'h1000) $display("FAIL nest_call%0d got %h want %h", k, bus.pc, 32'(k) * 32'h1000); else passCount++; checkCount++;
    end
    idle();
    bus.ret_valid = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.pc !== rets[k]) $display("FAIL nest_ret%0d got %h want %h", k, bus.pc, rets[k]); else passCount++; checkCount++;
    end
    tick();
    if (bus.pc !== 32'h1008 || bus.ras_underflow !== 1'b1) $display("FAIL ret_underflow got %h/%b want 00001008/1", bus.pc, bus.ras_underflow); else passCount++; checkCount++;
    idle();
    tick();
    if (bus.ras_underflow !== 1'b0) $display("FAIL underflow_end got %b want 0", bus.ras_underflow); else passCount++; checkCount++;
    bus.call_valid = 1; bus.ret_valid = 1; bus.jump_target = 32'h900;
    tick();
    if (bus.pc !== 32'h900) $display("FAIL call_beats_ret got %h want 00000900", bus.pc); else passCount++; checkCount++;
    idle();
  endtask
`endif

  task automatic test_async_reset();
    bus.call_valid = 1; bus.jump_target = 32'h700;
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    if (bus.pc !== RV || bus.pc_valid !== 1'b0) $display("FAIL async_rst got %h/%b want %h/0", bus.pc, bus.pc_valid, RV); else passCount++; checkCount++;
    tick();
    if (bus.pc !== RV) $display("FAIL async_hold got %h want %h", bus.pc, RV); else passCount++; checkCount++;
    idle();
    reset = 0;
    tick();
    if (bus.pc !== RV || bus.pc_valid !== 1'b1) $display("FAIL async_boot got %h/%b want %h/1", bus.pc, bus.pc_valid, RV); else passCount++; checkCount++;
`ifdef PC_SEQUENCER_RAS_EN
    bus.ret_valid = 1;
    tick();
    if (bus.pc !== 32'h404 || bus.ras_underflow !== 1'b1) $display("FAIL async_ras_empty got %h/%b want 00000404/1", bus.pc, bus.ras_underflow); else passCount++; checkCount++;
    idle();
`endif
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_back_to_back();
`ifdef PC_SEQUENCER_RAS_EN
    test_ras();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
